// File: rtl/fetch_pkg.sv
// Shared defaults and FSM encoding for the instruction fetch unit.
package fetch_pkg;

    localparam int unsigned ADDR_W_DEF = 7;
    localparam int unsigned INST_W_DEF = 32;
    localparam int unsigned DEPTH_DEF  = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FETCH = 1'b1
    } fetch_state_t;

    // Occupancy counter width able to represent 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: circular FIFO with flush and a registered head entry
// that holds its last value while the buffer is empty.
module fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 39,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [W-1:0]     head_data,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [W-1:0]     head_q, head_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (32'(p) == DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    // Next pointers/count, and the entry that will sit at the head next cycle.
    always_comb begin
        do_push  = 1'b0;
        do_pop   = 1'b0;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            do_pop  = pop && (count_q != '0);
            do_push = push && ((32'(count_q) != DEPTH) || do_pop);
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (do_push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
            if (count_d != '0) begin
                head_d = (do_push && (wr_ptr_q == rd_ptr_d)) ? push_data : mem[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    assign head_data = head_q;
    assign count     = count_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: local instruction store, PC sequencer with branch
// redirect, and a small prefetch buffer feeding decode.
module inst_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned INST_W = INST_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              stop,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_waddr,
    input  logic [INST_W-1:0] ls_wdata,
    output logic [INST_W-1:0] inst_out,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic              fetch_busy,
    output logic [2:0]        buf_count
);

    localparam int unsigned CNT_W       = cnt_width(DEPTH);
    localparam int unsigned OCC_W       = CNT_W + 1;
    localparam int unsigned ENTRY_W     = INST_W + ADDR_W;
    localparam int unsigned STORE_DEPTH = 1 << ADDR_W;

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              in_flight_q;
    logic [ADDR_W-1:0] rd_pc_q;
    logic [INST_W-1:0] rd_data_q;
    logic [INST_W-1:0] store_mem [STORE_DEPTH];

    logic              issue, flush, push, pop;
    logic [OCC_W-1:0]  occ;
    logic [CNT_W-1:0]  fifo_count;
    logic [ENTRY_W-1:0] head_data;

    // Sequencer: state transitions, PC update, read issue and flush.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        issue   = 1'b0;
        flush   = 1'b0;
        occ     = {1'b0, fifo_count} + OCC_W'(in_flight_q);
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    pc_d    = start_addr;
                end
            end
            ST_FETCH: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    flush   = 1'b1;
                end else if (branch_taken) begin
                    flush = 1'b1;
                    pc_d  = branch_target;
                end else if (occ < OCC_W'(DEPTH)) begin
                    issue = 1'b1;
                    pc_d  = pc_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            in_flight_q <= 1'b0;
            rd_pc_q     <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            in_flight_q <= issue;
            if (issue) begin
                rd_pc_q <= pc_q;
            end
        end
    end

    // Local store: read-first, contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (ls_we) begin
            store_mem[ls_waddr] <= ls_wdata;
        end
        if (issue) begin
            rd_data_q <= store_mem[pc_q];
        end
    end

    // A flush both drops the returning read and cancels any same-cycle pop.
    assign push = in_flight_q && !flush;
    assign pop  = inst_valid && inst_ready && !flush;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({rd_data_q, rd_pc_q}),
        .pop       (pop),
        .flush     (flush),
        .head_data (head_data),
        .count     (fifo_count)
    );

    assign inst_out   = head_data[ENTRY_W-1:ADDR_W];
    assign inst_pc    = head_data[ADDR_W-1:0];
    assign inst_valid = (fifo_count != '0);
    assign fetch_busy = (state_q == ST_FETCH);
    assign buf_count  = 3'(fifo_count);

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: sequencing, backpressure, branch,
// wrap-around, stop/branch priority and mid-fetch reset.
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [6:0]  start_addr;
    logic        stop;
    logic        branch_taken;
    logic [6:0]  branch_target;
    logic        ls_we;
    logic [6:0]  ls_waddr;
    logic [31:0] ls_wdata;
    logic [31:0] inst_out;
    logic [6:0]  inst_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic        fetch_busy;
    logic [2:0]  buf_count;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    inst_fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .start_addr    (start_addr),
        .stop          (stop),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .ls_we         (ls_we),
        .ls_waddr      (ls_waddr),
        .ls_wdata      (ls_wdata),
        .inst_out      (inst_out),
        .inst_pc       (inst_pc),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .fetch_busy    (fetch_busy),
        .buf_count     (buf_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] exp_data(input logic [6:0] a);
        if (a < 7'd16)                      return 32'h1000_0000 + 32'(a);
        else if (a >= 7'h40 && a < 7'h50)   return 32'h4000_0000 + 32'(a);
        else                                return 32'hAAAA_0000 + 32'(a);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, ".inst_out"},   inst_out,            32'h0);
        check({tag, ".inst_pc"},    32'(inst_pc),        32'h0);
        check({tag, ".inst_valid"}, 32'(inst_valid),     32'h0);
        check({tag, ".fetch_busy"}, 32'(fetch_busy),     32'h0);
        check({tag, ".buf_count"},  32'(buf_count),      32'h0);
    endtask

    task automatic check_head(input string tag, input logic [6:0] pc);
        check({tag, ".valid"}, 32'(inst_valid), 32'h1);
        check({tag, ".pc"},    32'(inst_pc),    32'(pc));
        check({tag, ".data"},  inst_out,        exp_data(pc));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; start_addr = '0; stop = 1'b0;
        branch_taken = 1'b0; branch_target = '0;
        ls_we = 1'b0; ls_waddr = '0; ls_wdata = '0; inst_ready = 1'b0;

        // Reset state
        tick(); tick();
        check_outputs_zero("reset");
        reset = 1'b0;

        // Load the whole store
        for (int a = 0; a < 128; a++) begin
            ls_we = 1'b1; ls_waddr = 7'(a); ls_wdata = exp_data(7'(a));
            tick();
        end
        ls_we = 1'b0;

        // Straight-line fetch from 0; a start while fetching is ignored
        inst_ready = 1'b1;
        start = 1'b1; start_addr = 7'h00;
        tick();
        start = 1'b1; start_addr = 7'h0C;
        check("seq.busy", 32'(fetch_busy), 32'h1);
        check("seq.valid_c1", 32'(inst_valid), 32'h0);
        tick();
        check("seq.valid_c2pre", 32'(inst_valid), 32'h0);
        tick();
        check_head("seq.pc0", 7'd0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            check_head("seq.pc", 7'(i));
        end
        start = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("seq.stop_busy",  32'(fetch_busy), 32'h0);
        check("seq.stop_valid", 32'(inst_valid), 32'h0);
        check("seq.stop_count", 32'(buf_count),  32'h0);

        // Backpressure: buffer fills to 4 then resumes without gaps
        inst_ready = 1'b0;
        start = 1'b1; start_addr = 7'h00;
        tick();
        start = 1'b0;
        repeat (7) tick();
        check("bp.count_full", 32'(buf_count), 32'h4);
        check_head("bp.head", 7'd0);
        repeat (3) tick();
        check("bp.count_hold", 32'(buf_count), 32'h4);
        inst_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check_head("bp.resume", 7'(i));
            tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;

        // Branch while three entries are buffered
        inst_ready = 1'b0;
        start = 1'b1; start_addr = 7'h00;
        tick();
        start = 1'b0;
        for (int k = 0; k < 10 && buf_count != 3'd3; k++) tick();
        check("br.count3", 32'(buf_count), 32'h3);
        branch_taken = 1'b1; branch_target = 7'h40; inst_ready = 1'b1;
        tick();
        branch_taken = 1'b0;
        check("br.count_flushed", 32'(buf_count),  32'h0);
        check("br.valid_c1",      32'(inst_valid), 32'h0);
        check("br.busy",          32'(fetch_busy), 32'h1);
        tick();
        check("br.valid_c2pre", 32'(inst_valid), 32'h0);
        tick();
        check_head("br.target", 7'h40);
        tick();
        check_head("br.target1", 7'h41);
        stop = 1'b1;
        tick();
        stop = 1'b0;

        // PC wrap-around from 0x7E
        start = 1'b1; start_addr = 7'h7E;
        tick();
        start = 1'b0;
        tick(); tick();
        check_head("wrap.7e", 7'h7E);
        tick();
        check_head("wrap.7f", 7'h7F);
        tick();
        check_head("wrap.00", 7'h00);
        tick();
        check_head("wrap.01", 7'h01);

        // Stop beats a simultaneous branch; branch in IDLE ignored
        stop = 1'b1; branch_taken = 1'b1; branch_target = 7'h20;
        tick();
        stop = 1'b0; branch_taken = 1'b0;
        check("sb.busy",  32'(fetch_busy), 32'h0);
        check("sb.count", 32'(buf_count),  32'h0);
        check("sb.valid", 32'(inst_valid), 32'h0);
        branch_taken = 1'b1; branch_target = 7'h30;
        tick();
        branch_taken = 1'b0;
        tick(); tick();
        check("idle_br.busy",  32'(fetch_busy), 32'h0);
        check("idle_br.valid", 32'(inst_valid), 32'h0);

        // Reset with two entries buffered and a read in flight
        inst_ready = 1'b0;
        start = 1'b1; start_addr = 7'h00;
        tick();
        start = 1'b0;
        for (int k = 0; k < 10 && buf_count != 3'd2; k++) tick();
        check("rst.count2", 32'(buf_count), 32'h2);
        reset = 1'b1;
        #1;
        check_outputs_zero("rst.async");
        tick();
        reset = 1'b0;
        repeat (3) tick();
        check("rst.no_valid", 32'(inst_valid), 32'h0);
        check("rst.no_busy",  32'(fetch_busy), 32'h0);

        // Start and stop together in IDLE: start wins
        inst_ready = 1'b1;
        start = 1'b1; stop = 1'b1; start_addr = 7'h05;
        tick();
        start = 1'b0; stop = 1'b0;
        check("ss.busy", 32'(fetch_busy), 32'h1);
        tick(); tick();
        check_head("ss.first", 7'h05);
        tick();
        check_head("ss.second", 7'h06);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/inst_fetch_unit.md
INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 7, meaning instruction local-store address width (128 words).
REQ-002 SHALL have parameter INST_W, default 32, meaning instruction width.
REQ-003 SHALL have parameter DEPTH, default 4, meaning instruction buffer entries.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  begin fetching at start_addr; honoured only in IDLE.
REQ-007 start_addr  input  ADDR_W  first fetch address.
REQ-008 stop  input  1  end fetching and flush; honoured in FETCH.
REQ-009 branch_taken  input  1  redirect request from branch unit.
REQ-010 branch_target  input  ADDR_W  redirect address, valid with branch_taken.
REQ-011 ls_we  input  1  loader write enable into instruction store.
REQ-012 ls_waddr  input  ADDR_W  loader write address.
REQ-013 ls_wdata  input  INST_W  loader write data.
REQ-014 inst_out  output  INST_W  head-of-buffer instruction.
REQ-015 inst_pc  output  ADDR_W  address of inst_out.
REQ-016 inst_valid  output  1  buffer non-empty.
REQ-017 inst_ready  input  1  decode accepts inst_out when inst_valid also high.
REQ-018 fetch_busy  output  1  high when state is FETCH.
REQ-019 buf_count  output  3  current buffer occupancy, 0..DEPTH.

Function
REQ-020 SHALL contain a 2^ADDR_W x INST_W store, synchronous write, synchronous read-first (same-cycle write and read at one address returns old data).
REQ-021 FSM states: IDLE, FETCH; IDLE->FETCH on start; FETCH->IDLE on stop; no other transitions.
REQ-022 In FETCH, a read SHALL be issued at PC each cycle where buf_count + in-flight < DEPTH; PC then increments modulo 2^ADDR_W (127 wraps to 0).
REQ-023 Read data SHALL enter the buffer one cycle after issue, tagged with its PC.
REQ-024 First inst_valid SHALL assert 2 cycles after start (or branch_taken) is sampled.
REQ-025 Pop occurs when inst_valid && inst_ready; push and pop in the same cycle leave buf_count unchanged.
REQ-026 Buffer full: no read issued; buffer empty: inst_valid low, inst_out/inst_pc hold last value.
REQ-027 branch_taken in FETCH SHALL flush the buffer (buf_count=0), discard any in-flight read, and set PC=branch_target; a same-cycle pop is cancelled.
REQ-028 branch_taken in IDLE SHALL be ignored.
REQ-029 stop SHALL flush buffer and in-flight read; stop wins over simultaneous branch_taken.
REQ-030 start in FETCH SHALL be ignored; start and stop together in IDLE: start honoured.
REQ-031 Loader writes SHALL be accepted in any state.

Reset
REQ-032 reset SHALL force state IDLE, PC 0, buffer empty, in-flight cleared, inst_out 0, inst_pc 0, inst_valid 0, fetch_busy 0, buf_count 0.
REQ-033 Store contents SHALL NOT be reset.
REQ-034 reset asserted mid-fetch SHALL abandon all pending reads; first post-reset activity requires start.

Structure
REQ-035 Package fetch_pkg SHALL hold ADDR_W/INST_W/DEPTH defaults and the FSM state encoding.
REQ-036 Buffer SHALL be a sub-module fetch_fifo (DEPTH x (INST_W+ADDR_W), push/pop/flush, count).

Verification
REQ-037 Load addr 0..7 with 0x1000_0000+i, start at 0, inst_ready=1 -> inst_valid at cycle 2, inst_pc 0,1,2,... one per cycle, data matches.
REQ-038 inst_ready=0 after start -> buf_count saturates at 4, no further reads, pc sequence resumes gap-free when inst_ready=1.
REQ-039 branch_taken, target 0x40, while buffer holds 3 -> buf_count 0 next cycle, next inst_pc 0x40 two cycles later, no stale entry delivered.
REQ-040 start_addr 0x7E -> inst_pc 0x7E, 0x7F, 0x00, 0x01.
REQ-041 stop and branch_taken same cycle -> IDLE, buf_count 0, inst_valid 0, PC not redirected.
REQ-042 reset asserted with 2 entries buffered and read in flight -> all outputs 0 immediately, no inst_valid until new start.
